// File: rtl/fifo_stream_reader.sv
// Read-domain consumer for async_fifo: pops into a 2-entry skid buffer and presents a
// framed valid/ready stream, so m_ready never reaches rinc combinationally.
module fifo_stream_reader #(
    parameter int DSIZE     = 8,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    input  logic             flush,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [CNT_W-1:0] frames_done
);

    localparam int             BW        = $clog2(FRAME_LEN);
    localparam logic [BW-1:0]  LAST_BEAT = BW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL2 = 2'd2
    } buf_state_e;

    buf_state_e       state_q;
    logic [DSIZE-1:0] h0_q;
    logic [DSIZE-1:0] h1_q;
    logic [BW-1:0]    beat_q, beat_d;
    logic [CNT_W-1:0] frames_q, frames_d;
    logic             out_fire;

    // The pop decision uses only registered state and FIFO/flush inputs.
    assign rinc        = rrst_n & ~rempty & (state_q != FULL2) & ~flush;
    assign m_valid     = (state_q != EMPTY);
    assign m_data      = h0_q;
    assign out_fire    = m_valid & m_ready;
    assign m_last      = m_valid & (beat_q == LAST_BEAT);
    assign frames_done = frames_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= EMPTY;
            h0_q    <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (rinc) begin
                        h0_q    <= rdata;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (rinc && out_fire) begin
                        h0_q <= rdata;
                    end else if (rinc) begin
                        state_q <= FULL2;
                    end else if (out_fire) begin
                        state_q <= EMPTY;
                    end
                end
                FULL2: begin
                    if (out_fire) begin
                        h0_q    <= h1_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    // NOTE: h1 is a pure data register that is only read once the state says it
    // holds a word, so it carries no reset and stays a plain enable flop.
    always_ff @(posedge rclk) begin
        if (state_q == ONE && rinc && !out_fire) begin
            h1_q <= rdata;
        end
    end

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        beat_d   = beat_q;
        frames_d = frames_q;
        if (flush) begin
            beat_d = '0;
        end else if (out_fire) begin
            if (m_last) begin
                beat_d   = '0;
                frames_d = frames_q + 1'b1;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            beat_q   <= '0;
            frames_q <= '0;
        end else begin
            beat_q   <= beat_d;
            frames_q <= frames_d;
        end
    end

endmodule
